// File: rtl/lc3b_mem_arbiter_pkg.sv
// Shared constants for the LC-3b memory arbiter: widths, FSM encoding and grant ids.
package lc3b_pkg;

  localparam int LC3B_ADDR_W = 16;
  localparam int LC3B_DATA_W = 16;
  localparam int WAIT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_D  = 1'b1;

endpackage

// File: rtl/lc3b_mem_arbiter_wait_counter.sv
// Down-counter that times a fixed-latency memory access; zero marks the last access cycle.
module lc3b_wait_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/lc3b_mem_arbiter.sv
// Arbitrates the single-port LC-3b memory between instruction fetch and load/store,
// data first, with a starvation guard that forces a fetch after STARVE_LIM data wins.
module lc3b_mem_arbiter
  import lc3b_pkg::*;
#(
  parameter int ADDR_W     = LC3B_ADDR_W,
  parameter int DATA_W     = LC3B_DATA_W,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_LIM = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [1:0]        state
);

  localparam int SW = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
  localparam logic [SW-1:0]     STARVE_MAX = SW'(STARVE_LIM);
  localparam logic [WAIT_W-1:0] WAIT_LOAD  = WAIT_W'(MEM_LAT - 1);

  state_t        state_q;
  logic          gnt;
  logic [SW-1:0] starve_cnt;
  logic          any_req;
  logic          pick_d;
  logic          wc_load;
  logic          wc_dec;
  logic          wc_zero;

  // D wins by default; a fetch that has watched STARVE_LIM data grants goes first.
  assign any_req = if_req | d_req;
  assign pick_d  = d_req & ~(if_req & (starve_cnt == STARVE_MAX));

  assign wc_load = (state_q == ST_IDLE) & any_req;
  assign wc_dec  = (state_q == ST_ACCESS) & ~wc_zero;

  lc3b_wait_counter #(
    .W (WAIT_W)
  ) u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (wc_load),
    .load_val (WAIT_LOAD),
    .dec      (wc_dec),
    .zero     (wc_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gnt        <= GNT_IF;
      starve_cnt <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            state_q <= ST_ACCESS;
            mem_en  <= 1'b1;
            if (pick_d) begin
              gnt       <= GNT_D;
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              if (!if_req) begin
                starve_cnt <= '0;
              end else if (starve_cnt != STARVE_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
              end
            end else begin
              gnt        <= GNT_IF;
              mem_we     <= 1'b0;
              mem_addr   <= if_addr;
              starve_cnt <= '0;
            end
          end
        end
        ST_ACCESS: begin
          // Memory read data is only guaranteed in the last access cycle.
          if (wc_zero) begin
            state_q <= ST_DONE;
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            if (gnt == GNT_IF) begin
              if_ack   <= 1'b1;
              if_rdata <= mem_rdata;
            end else begin
              d_ack <= 1'b1;
              if (!mem_we) begin
                d_rdata <= mem_rdata;
              end
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy  = (state_q == ST_ACCESS) | (state_q == ST_DONE);
  assign state = state_q;

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// Directed bench for lc3b_mem_arbiter: MEM_LAT=2 instance for fetch/store/priority/
// starvation/reset, and a MEM_LAT=1 instance for back-to-back fetches.
module tb_lc3b_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // instance A: MEM_LAT=2, STARVE_LIM=3
  logic        if_req, if_ack, d_req, d_we, d_ack, mem_en, mem_we, busy;
  logic [15:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  state;

  // instance B: MEM_LAT=1
  logic        b_if_req, b_if_ack, b_d_req, b_d_we, b_d_ack, b_mem_en, b_mem_we, b_busy;
  logic [15:0] b_if_addr, b_if_rdata, b_d_addr, b_d_wdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [1:0]  b_state;

  lc3b_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(2), .STARVE_LIM(3)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .state(state)
  );

  lc3b_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1), .STARVE_LIM(3)) u_dut_b (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ack(b_if_ack),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_rdata(b_d_rdata), .d_ack(b_d_ack),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .busy(b_busy), .state(b_state)
  );

  // Memory model: fixed contents plus one writable word at 0x0200.
  logic [15:0] wr_word = 16'h0000;

  function automatic logic [15:0] rom(input logic [15:0] a);
    case (a)
      16'h0010: rom = 16'h1234;
      16'h0020: rom = 16'h5A5A;
      16'h0030: rom = 16'h0C0C;
      16'h0040: rom = 16'h7777;
      16'h0050: rom = 16'hA5A5;
      default:  rom = 16'h0000;
    endcase
  endfunction

  assign mem_rdata   = (mem_addr == 16'h0200) ? wr_word : rom(mem_addr);
  assign b_mem_rdata = rom(b_mem_addr);

  always @(posedge clk) begin
    if (mem_en && mem_we && (mem_addr == 16'h0200)) wr_word <= mem_wdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_miss++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One grant on instance A, called from the IDLE cycle that samples the request.
  task automatic serve(input string tag, input logic [15:0] exp_addr,
                       input logic exp_d, input logic [15:0] exp_rdata);
    tick();
    check({tag, " mem_en"}, 32'(mem_en), 32'h1);
    check({tag, " mem_addr"}, 32'(mem_addr), 32'(exp_addr));
    tick();
    check({tag, " mem_en 2nd"}, 32'(mem_en), 32'h1);
    check({tag, " if_ack pre"}, 32'(if_ack), 32'h0);
    tick();
    check({tag, " d_ack"}, 32'(d_ack), 32'(exp_d));
    check({tag, " if_ack"}, 32'(if_ack), 32'(!exp_d));
    check({tag, " mem_en done"}, 32'(mem_en), 32'h0);
    if (exp_d) check({tag, " d_rdata"}, 32'(d_rdata), 32'(exp_rdata));
    else       check({tag, " if_rdata"}, 32'(if_rdata), 32'(exp_rdata));
    tick();
    check({tag, " idle"}, 32'(state), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  logic [15:0] b_addrs [3];
  logic [15:0] b_exp   [3];

  initial begin
    rst = 1'b1;
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    b_if_req = 0; b_if_addr = 0; b_d_req = 0; b_d_we = 0; b_d_addr = 0; b_d_wdata = 0;
    tick(); tick();
    rst = 1'b0;

    // reset state
    check("rst state", 32'(state), 32'h0);
    check("rst mem_en", 32'(mem_en), 32'h0);
    check("rst acks", 32'({if_ack, d_ack}), 32'h0);
    check("rst rdata", 32'({if_rdata, d_rdata}), 32'h0);
    check("rst busy", 32'(busy), 32'h0);
    tick();

    // 1. single fetch
    if_req = 1; if_addr = 16'h0010;
    tick();
    check("t1 c1 mem_en", 32'(mem_en), 32'h1);
    check("t1 c1 mem_we", 32'(mem_we), 32'h0);
    check("t1 c1 mem_addr", 32'(mem_addr), 32'h0010);
    check("t1 c1 busy", 32'(busy), 32'h1);
    tick();
    check("t1 c2 mem_en", 32'(mem_en), 32'h1);
    check("t1 c2 if_ack", 32'(if_ack), 32'h0);
    tick();
    check("t1 c3 if_ack", 32'(if_ack), 32'h1);
    check("t1 c3 if_rdata", 32'(if_rdata), 32'h1234);
    check("t1 c3 mem_en", 32'(mem_en), 32'h0);
    check("t1 c3 state", 32'(state), 32'h2);
    if_req = 0;
    tick();
    check("t1 c4 if_ack", 32'(if_ack), 32'h0);
    check("t1 c4 busy", 32'(busy), 32'h0);

    // 2. store
    d_req = 1; d_we = 1; d_addr = 16'h0200; d_wdata = 16'hBEEF;
    tick();
    check("t2 c1 mem_we", 32'(mem_we), 32'h1);
    check("t2 c1 mem_addr", 32'(mem_addr), 32'h0200);
    check("t2 c1 mem_wdata", 32'(mem_wdata), 32'hBEEF);
    tick();
    check("t2 c2 mem_we", 32'(mem_we), 32'h1);
    tick();
    check("t2 c3 d_ack", 32'(d_ack), 32'h1);
    check("t2 c3 if_ack", 32'(if_ack), 32'h0);
    check("t2 c3 d_rdata", 32'(d_rdata), 32'h0);
    check("t2 c3 mem_we", 32'(mem_we), 32'h0);
    d_req = 0; d_we = 0;
    tick();
    check("t2 hold addr", 32'(mem_addr), 32'h0200);
    check("t2 hold wdata", 32'(mem_wdata), 32'hBEEF);

    // 3. simultaneous: D load first, then fetch
    if_req = 1; if_addr = 16'h0010; d_req = 1; d_addr = 16'h0200;
    serve("t3 d", 16'h0200, 1'b1, 16'hBEEF);
    d_req = 0;
    serve("t3 if", 16'h0010, 1'b0, 16'h1234);
    if_req = 0;

    // 4. starvation: three D grants, forced fetch, then D again
    if_req = 1; if_addr = 16'h0020; d_req = 1; d_addr = 16'h0030;
    serve("t4 d1", 16'h0030, 1'b1, 16'h0C0C);
    serve("t4 d2", 16'h0030, 1'b1, 16'h0C0C);
    serve("t4 d3", 16'h0030, 1'b1, 16'h0C0C);
    serve("t4 if", 16'h0020, 1'b0, 16'h5A5A);
    serve("t4 d4", 16'h0030, 1'b1, 16'h0C0C);
    if_req = 0; d_req = 0;

    // 5. reset in the first ACCESS cycle
    if_req = 1; if_addr = 16'h0040;
    tick();
    check("t5 access", 32'(mem_en), 32'h1);
    rst = 1'b1;
    tick();
    check("t5 state", 32'(state), 32'h0);
    check("t5 mem_en", 32'(mem_en), 32'h0);
    check("t5 mem_addr", 32'(mem_addr), 32'h0);
    check("t5 mem_wdata", 32'(mem_wdata), 32'h0);
    check("t5 rdata", 32'({if_rdata, d_rdata}), 32'h0);
    check("t5 acks", 32'({if_ack, d_ack}), 32'h0);
    rst = 1'b0; if_req = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5 no ack", 32'({if_ack, d_ack}), 32'h0);
      check("t5 if_rdata", 32'(if_rdata), 32'h0);
    end

    // 6. MEM_LAT=1 back-to-back fetches
    b_addrs[0] = 16'h0010; b_exp[0] = 16'h1234;
    b_addrs[1] = 16'h0020; b_exp[1] = 16'h5A5A;
    b_addrs[2] = 16'h0050; b_exp[2] = 16'hA5A5;
    b_if_req = 1; b_if_addr = b_addrs[0];
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t6 f%0d mem_en", i), 32'(b_mem_en), 32'h1);
      check($sformatf("t6 f%0d mem_addr", i), 32'(b_mem_addr), 32'(b_addrs[i]));
      tick();
      check($sformatf("t6 f%0d if_ack", i), 32'(b_if_ack), 32'h1);
      check($sformatf("t6 f%0d done mem_en", i), 32'(b_mem_en), 32'h0);
      check($sformatf("t6 f%0d if_rdata", i), 32'(b_if_rdata), 32'(b_exp[i]));
      if (i < 2) b_if_addr = b_addrs[i + 1];
      else       b_if_req = 0;
      tick();
      check($sformatf("t6 f%0d idle ack", i), 32'(b_if_ack), 32'h0);
      check($sformatf("t6 f%0d idle state", i), 32'(b_state), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
